regfile_wport_ctrl: RTL and testbench

Write-port controller for the 32×32 register file (`RegFile`). It shares the file's single write port between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). It also keeps a busy scoreboard for registers with MDU results still in flight, and guarantees the MDU cannot be starved by continuous writebacks. It sits between WB/MDU and `RegFile`; its outputs drive `RegFile`'s `regWrite`, `writeReg` and `writeData` directly.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 56 +++++
 rtl/regfile_wport_ctrl.sv | 112 +++++++++++
 tb/tb_regfile_wport_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the register-file write port
//                controller and its busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // NORMAL: writeback has priority. FORCE: one cycle in which the MDU
    // owns the write port and writeback is stalled.
    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } wport_state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Busy bits for registers with an MDU result still in flight.
//                Set on issue, cleared on MDU handshake; set wins a collision.
//                Entry 0 (x0) is never busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              i_setEn,
    input  logic [ADDR_W-1:0] i_setAddr,
    input  logic              i_clrEn,
    input  logic [ADDR_W-1:0] i_clrAddr,
    input  logic [ADDR_W-1:0] i_rdAddrA,
    input  logic [ADDR_W-1:0] i_rdAddrB,
    output logic              o_rdBusyA,
    output logic              o_rdBusyB
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busyNext;

    // Clear first so that a same-cycle set on the same register wins.
    always_comb begin
        w_busyNext = r_busy;
        if (i_clrEn) begin
            w_busyNext[i_clrAddr] = 1'b0;
        end
        if (i_setEn && (i_setAddr != '0)) begin
            w_busyNext[i_setAddr] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    // Reads come from the register only; a clear becomes visible next cycle.
    assign o_rdBusyA = r_busy[i_rdAddrA];
    assign o_rdBusyB = r_busy[i_rdAddrB];

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_wport_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wport_ctrl
//  Description : Arbitrates the single RegFile write port between writeback
//                and the MDU, forces an MDU grant after STARVE_LIMIT blocked
//                cycles, and tracks in-flight MDU destinations.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wport_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W       = regfile_pkg::DATA_W,
    parameter int ADDR_W       = regfile_pkg::ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              stall_wb,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData
);

    localparam int          CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    wport_state_t     r_state;
    wport_state_t     w_stateNext;
    logic [CNT_W-1:0] r_starveCnt;
    logic [CNT_W-1:0] w_starveCntNext;
    logic             w_wbReq;
    logic             w_wbGrant;
    logic             w_mduGrant;

    // Arbitration, write-port drive and starvation bookkeeping. Grants are
    // gated by reset so the port is quiet while reset is held.
    always_comb begin
        w_wbReq         = wb_we && (wb_addr != '0);
        w_wbGrant       = reset && (r_state == NORMAL) && w_wbReq;
        w_mduGrant      = reset && mdu_valid && ((r_state == FORCE) || !w_wbReq);
        regWrite        = 1'b0;
        writeReg        = '0;
        writeData       = '0;
        w_starveCntNext = '0;
        w_stateNext     = r_state;

        if (w_wbGrant) begin
            regWrite  = 1'b1;
            writeReg  = wb_addr;
            writeData = wb_data;
        end else if (w_mduGrant) begin
            regWrite  = (mdu_addr != '0);
            writeReg  = mdu_addr;
            writeData = mdu_data;
        end

        if (mdu_valid && !w_mduGrant) begin
            w_starveCntNext = r_starveCnt + CNT_W'(1);
        end

        case (r_state)
            NORMAL: if (w_starveCntNext == C_LIMIT) w_stateNext = FORCE;
            FORCE:  if (w_mduGrant || !mdu_valid)   w_stateNext = NORMAL;
            default: w_stateNext = NORMAL;
        endcase
    end

    // State and starvation counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= NORMAL;
            r_starveCnt <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_starveCnt <= w_starveCntNext;
        end
    end

    assign mdu_ready = w_mduGrant;
    assign stall_wb  = (r_state == FORCE);

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (1 << ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .i_setEn   (issue_valid),
        .i_setAddr (issue_addr),
        .i_clrEn   (w_mduGrant),
        .i_clrAddr (mdu_addr),
        .i_rdAddrA (rs1),
        .i_rdAddrB (rs2),
        .o_rdBusyA (rs1_busy),
        .o_rdBusyB (rs2_busy)
    );

endmodule : regfile_wport_ctrl
`default_nettype wire

// File: tb/tb_regfile_wport_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wport_ctrl
//  Description : Directed self-checking bench for regfile_wport_ctrl, with a
//                behavioural RegFile fed from the write-port outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wport_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_we, mdu_valid, issue_valid;
    logic [AW-1:0] wb_addr, mdu_addr, issue_addr, rs1, rs2;
    logic [DW-1:0] wb_data, mdu_data;
    logic          mdu_ready, rs1_busy, rs2_busy, stall_wb, regWrite;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;

    logic [DW-1:0] rf [0:31];

    int nVec  = 0;
    int nFail = 0;

    regfile_wport_ctrl #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .stall_wb(stall_wb), .regWrite(regWrite),
        .writeReg(writeReg), .writeData(writeData)
    );

    always #5 clk = ~clk;

    // Behavioural RegFile written from the controller's port.
    always @(posedge clk) begin
        if (regWrite) rf[writeReg] <= writeData;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we = 0; wb_addr = 0; wb_data = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
        issue_valid = 0; issue_addr = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        wb_we = 1; wb_addr = 3; wb_data = 32'h55; mdu_valid = 1; mdu_addr = 2;
        #2;
        nVec++; if (stall_wb !== 1'b0) begin nFail++; $display("FAIL rst_stall got=%b exp=0", stall_wb); end
        nVec++; if (regWrite !== 1'b0) begin nFail++; $display("FAIL rst_regWrite got=%b exp=0", regWrite); end
        nVec++; if (mdu_ready !== 1'b0) begin nFail++; $display("FAIL rst_mdu_ready got=%b exp=0", mdu_ready); end
        nVec++; if (writeReg !== 5'd0) begin nFail++; $display("FAIL rst_writeReg got=%0d exp=0", writeReg); end
        nVec++; if (writeData !== 32'd0) begin nFail++; $display("FAIL rst_writeData got=%0h exp=0", writeData); end
        tick(); tick();
        idle();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_wb_priority();
        idle();
        wb_we = 1; wb_addr = 4; wb_data = 12; mdu_valid = 1; mdu_addr = 5; mdu_data = 6;
        @(negedge clk);
        nVec++; if (regWrite !== 1'b1) begin nFail++; $display("FAIL prio_regWrite got=%b exp=1", regWrite); end
        nVec++; if (writeReg !== 5'd4) begin nFail++; $display("FAIL prio_writeReg got=%0d exp=4", writeReg); end
        nVec++; if (writeData !== 32'd12) begin nFail++; $display("FAIL prio_writeData got=%0d exp=12", writeData); end
        nVec++; if (mdu_ready !== 1'b0) begin nFail++; $display("FAIL prio_mdu_ready got=%b exp=0", mdu_ready); end
        tick();
        wb_we = 0;
        @(negedge clk);
        nVec++; if (writeReg !== 5'd5) begin nFail++; $display("FAIL mdu_writeReg got=%0d exp=5", writeReg); end
        nVec++; if (writeData !== 32'd6) begin nFail++; $display("FAIL mdu_writeData got=%0d exp=6", writeData); end
        nVec++; if (mdu_ready !== 1'b1) begin nFail++; $display("FAIL mdu_ready got=%b exp=1", mdu_ready); end
        nVec++; if (regWrite !== 1'b1) begin nFail++; $display("FAIL mdu_regWrite got=%b exp=1", regWrite); end
        tick();
        idle();
        @(negedge clk);
        nVec++; if (rf[5] !== 32'd6) begin nFail++; $display("FAIL rf_x5 got=%0d exp=6", rf[5]); end
        nVec++; if (rf[4] !== 32'd12) begin nFail++; $display("FAIL rf_x4 got=%0d exp=12", rf[4]); end
        tick();
    endtask

    task automatic test_starvation();
        idle();
        wb_we = 1; wb_addr = 7; wb_data = 77; mdu_valid = 1; mdu_addr = 8; mdu_data = 88;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            nVec++; if (stall_wb !== 1'b0) begin nFail++; $display("FAIL starve_stall_c%0d got=%b exp=0", c, stall_wb); end
            nVec++; if (mdu_ready !== 1'b0) begin nFail++; $display("FAIL starve_ready_c%0d got=%b exp=0", c, mdu_ready); end
            nVec++; if (writeReg !== 5'd7) begin nFail++; $display("FAIL starve_writeReg_c%0d got=%0d exp=7", c, writeReg); end
            tick();
        end
        @(negedge clk);
        nVec++; if (stall_wb !== 1'b1) begin nFail++; $display("FAIL force_stall got=%b exp=1", stall_wb); end
        nVec++; if (mdu_ready !== 1'b1) begin nFail++; $display("FAIL force_ready got=%b exp=1", mdu_ready); end
        nVec++; if (writeReg !== 5'd8) begin nFail++; $display("FAIL force_writeReg got=%0d exp=8", writeReg); end
        nVec++; if (writeData !== 32'd88) begin nFail++; $display("FAIL force_writeData got=%0d exp=88", writeData); end
        tick();
        mdu_valid = 0;
        @(negedge clk);
        nVec++; if (stall_wb !== 1'b0) begin nFail++; $display("FAIL after_force_stall got=%b exp=0", stall_wb); end
        nVec++; if (writeReg !== 5'd7) begin nFail++; $display("FAIL after_force_writeReg got=%0d exp=7", writeReg); end
        nVec++; if (regWrite !== 1'b1) begin nFail++; $display("FAIL after_force_regWrite got=%b exp=1", regWrite); end
        tick();
        idle();
        @(negedge clk);
        nVec++; if (rf[8] !== 32'd88) begin nFail++; $display("FAIL rf_x8 got=%0d exp=88", rf[8]); end
        tick();
    endtask

    task automatic test_x0();
        idle();
        wb_we = 1; wb_addr = 0; wb_data = 99; mdu_valid = 1; mdu_addr = 3; mdu_data = 33;
        @(negedge clk);
        nVec++; if (mdu_ready !== 1'b1) begin nFail++; $display("FAIL x0wb_ready got=%b exp=1", mdu_ready); end
        nVec++; if (writeReg !== 5'd3) begin nFail++; $display("FAIL x0wb_writeReg got=%0d exp=3", writeReg); end
        nVec++; if (writeData !== 32'd33) begin nFail++; $display("FAIL x0wb_writeData got=%0d exp=33", writeData); end
        tick();
        wb_we = 0; mdu_addr = 0; mdu_data = 44;
        @(negedge clk);
        nVec++; if (mdu_ready !== 1'b1) begin nFail++; $display("FAIL x0mdu_ready got=%b exp=1", mdu_ready); end
        nVec++; if (regWrite !== 1'b0) begin nFail++; $display("FAIL x0mdu_regWrite got=%b exp=0", regWrite); end
        tick();
        idle();
        issue_valid = 1; issue_addr = 0; rs1 = 0;
        tick();
        issue_valid = 0;
        @(negedge clk);
        nVec++; if (rs1_busy !== 1'b0) begin nFail++; $display("FAIL x0_busy got=%b exp=0", rs1_busy); end
        nVec++; if (rf[0] === 32'd44) begin nFail++; $display("FAIL rf_x0 got=%0d exp=not 44", rf[0]); end
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        rs1 = 10; rs2 = 9;
        issue_valid = 1; issue_addr = 9;
        @(negedge clk);
        nVec++; if (rs2_busy !== 1'b0) begin nFail++; $display("FAIL sb_pre got=%b exp=0", rs2_busy); end
        tick();
        // Set and clear on x9 in the same cycle.
        mdu_valid = 1; mdu_addr = 9; mdu_data = 909;
        @(negedge clk);
        nVec++; if (rs2_busy !== 1'b1) begin nFail++; $display("FAIL sb_set got=%b exp=1", rs2_busy); end
        tick();
        // Handshake on x9 alone, issue to x10 in the same cycle.
        issue_addr = 10;
        @(negedge clk);
        nVec++; if (rs2_busy !== 1'b1) begin nFail++; $display("FAIL sb_collide got=%b exp=1", rs2_busy); end
        nVec++; if (mdu_ready !== 1'b1) begin nFail++; $display("FAIL sb_hs_ready got=%b exp=1", mdu_ready); end
        tick();
        idle(); rs1 = 10; rs2 = 9;
        @(negedge clk);
        nVec++; if (rs2_busy !== 1'b0) begin nFail++; $display("FAIL sb_clear got=%b exp=0", rs2_busy); end
        nVec++; if (rs1_busy !== 1'b1) begin nFail++; $display("FAIL sb_x10 got=%b exp=1", rs1_busy); end
        tick();
        // A WB write to busy x10 lands and leaves it busy.
        wb_we = 1; wb_addr = 10; wb_data = 1010;
        tick();
        wb_we = 0;
        @(negedge clk);
        nVec++; if (rs1_busy !== 1'b1) begin nFail++; $display("FAIL sb_wb_keep got=%b exp=1", rs1_busy); end
        nVec++; if (rf[10] !== 32'd1010) begin nFail++; $display("FAIL rf_x10 got=%0d exp=1010", rf[10]); end
        tick();
    endtask

    task automatic test_reset_mid_force();
        idle();
        issue_valid = 1; issue_addr = 4;
        tick();
        issue_valid = 0; rs1 = 4;
        wb_we = 1; wb_addr = 7; wb_data = 5; mdu_valid = 1; mdu_addr = 11; mdu_data = 1;
        for (int c = 0; c < 4; c++) tick();
        @(negedge clk);
        nVec++; if (stall_wb !== 1'b1) begin nFail++; $display("FAIL mid_force_stall got=%b exp=1", stall_wb); end
        nVec++; if (rs1_busy !== 1'b1) begin nFail++; $display("FAIL mid_force_busy got=%b exp=1", rs1_busy); end
        #1 reset = 1'b0;
        #1;
        nVec++; if (stall_wb !== 1'b0) begin nFail++; $display("FAIL mrst_stall got=%b exp=0", stall_wb); end
        nVec++; if (regWrite !== 1'b0) begin nFail++; $display("FAIL mrst_regWrite got=%b exp=0", regWrite); end
        nVec++; if (mdu_ready !== 1'b0) begin nFail++; $display("FAIL mrst_ready got=%b exp=0", mdu_ready); end
        nVec++; if (rs1_busy !== 1'b0) begin nFail++; $display("FAIL mrst_busy got=%b exp=0", rs1_busy); end
        tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        // Back in NORMAL: WB wins, MDU blocked again.
        nVec++; if (stall_wb !== 1'b0) begin nFail++; $display("FAIL post_rst_stall got=%b exp=0", stall_wb); end
        nVec++; if (writeReg !== 5'd7) begin nFail++; $display("FAIL post_rst_writeReg got=%0d exp=7", writeReg); end
        nVec++; if (mdu_ready !== 1'b0) begin nFail++; $display("FAIL post_rst_ready got=%b exp=0", mdu_ready); end
        tick();
        idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        idle();
        reset = 1'b1;
        #3;
        test_reset();
        test_wb_priority();
        test_starvation();
        test_x0();
        test_scoreboard();
        test_reset_mid_force();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule : tb_regfile_wport_ctrl
`default_nettype wire
